switch_hex_monitor: RTL and testbench
=====================================

# switch_hex_monitor

Parametrised board front-panel block: debounces up to six slide switches, mirrors each debounced switch on an LED, and shows per-channel information on a seven-segment digit. The digit shows either the switch state (0/1) or a 4-bit count of debounced off→on transitions, selected at run time. It sits directly between the board pins (SW, LEDR, HEX0–HEX5) and the rest of the top level.

## Interface
Parameters:
- CHANNELS, 6: number of active switch channels, legal 1..6.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a switch change, legal ≥2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- SW  input  CHANNELS  raw asynchronous switch inputs, 1 = up.
- mode  input  1  0 = digits show state, 1 = digits show transition count.
- clr  input  1  synchronous clear of all transition counters.
- LEDR  output  CHANNELS  debounced switch state, 1 = lit.
- HEX0..HEX5  output  8 each  active-low segments {dp,g,f,e,d,c,b,a}.

## Operation
- Per channel: two-flop synchroniser, then debouncer, then edge detector and 4-bit transition counter.
- Debouncer: a counter runs while the synchronised input differs from the debounced state. It resets to 0 whenever the input equals the debounced state.
  - When the input has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced state takes the new value and the counter clears.
- A debounced 0→1 transition increments that channel's counter. Counting is modulo 16, so 15 wraps to 0. A 1→0 transition does not count.
- clr = 1 zeroes all counters. If clr coincides with an increment, clr wins and the counter is 0.
- LEDR[i] = debounced state of channel i.
- HEXi for i < CHANNELS:
  - mode = 0: shows the state digit, 8'hF9 for 1 and 8'hC0 for 0.
  - mode = 1: shows the count as a hex glyph 0–F; dp is always off (bit 7 = 1).
- HEXi for i ≥ CHANNELS: constant 8'hFF (blank).
- Hex glyphs: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- Reset values (reset_n = 0 at a clock edge):
  - Synchronisers, debounced states, debounce counters and transition counters all 0.
  - LEDR = 0.
  - Active HEX = 8'hC0; inactive HEX = 8'hFF.
- Reset asserted mid-debounce discards the partial count. A switch that is already up at reset release is accepted after a full debounce and counts as one transition.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- Raw SW change (stable) → LEDR change: 2 + DEBOUNCE_CYCLES cycles.
- HEX update (state or count) follows 1 cycle after the LEDR change.
- mode change → HEX update: 1 cycle. clr → HEX showing 0 (mode = 1): 1 cycle.
- Glitch rule: a pulse shorter than DEBOUNCE_CYCLES synchronised cycles never changes LEDR or the counters.
- A glitch that reverts resets the debounce count, so acceptance requires an uninterrupted run.

## Configuration
- SWITCH_HEX_MONITOR_DEBOUNCE_EN defined: the debouncer is as described above.
- Macro undefined: the debouncer is removed and the debounced state equals the synchroniser output.
  - DEBOUNCE_CYCLES is ignored.
  - SW → LEDR latency becomes 2 cycles; HEX follows 1 cycle later.
  - Every synchronised 0→1 transition counts.

## Test plan
All scenarios use CHANNELS = 4, DEBOUNCE_CYCLES = 4, with the macro defined unless stated.
- Reset with SW = 4'b1010 held → LEDR = 0, HEX0–3 = C0, HEX4/5 = FF during reset. LEDR = 4'b1010 exactly 6 cycles after release; HEX1/HEX3 = F9 one cycle later.
- SW[0] glitches high for 3 cycles, then low → LEDR[0] stays 0 and count0 stays 0. A later high for 6 cycles → LEDR[0] = 1 and count0 = 1.
- mode = 1, SW[2] toggled up/down 17 times with stable periods of 8 cycles → HEX2 shows 1 (count wraps to 1) and LEDR[2] ends at 0.
- clr asserted in the same cycle as the debounced rise on SW[1] → count1 = 0 and HEX1 = C0 in mode 1.
- mode toggled 0→1→0 with count3 = 10 and SW[3] = 1 → HEX3 shows F9, then 88, then F9, each 1 cycle after the mode edge.
- Macro undefined: SW[0] 1-cycle pulse → LEDR[0] high for exactly 1 cycle, 2 cycles later; count0 increments.

Source files
------------

// File: rtl/switch_hex_monitor_if.sv
// Board-pin bundle between the front-panel monitor and the top level:
// raw switches and controls in, LEDs and seven-segment digits out.
interface switch_hex_monitor_if #(
    parameter int CHANNELS = 6
);
    logic [CHANNELS-1:0] SW;
    logic                mode;
    logic                clr;
    logic [CHANNELS-1:0] LEDR;
    logic [7:0]          HEX0;
    logic [7:0]          HEX1;
    logic [7:0]          HEX2;
    logic [7:0]          HEX3;
    logic [7:0]          HEX4;
    logic [7:0]          HEX5;

    modport master (
        output SW, mode, clr,
        input  LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  SW, mode, clr,
        output LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface

// File: rtl/switch_hex_monitor.sv
// Switch synchroniser/debouncer with LED mirror, off->on counters and hex digits.
// Define SWITCH_HEX_MONITOR_DEBOUNCE_EN to enable the debouncer; otherwise state follows the synchroniser.
module switch_hex_monitor #(
    parameter int CHANNELS        = 6,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic                 clk,
    input logic                 reset_n,
    switch_hex_monitor_if.slave bus
);

    function automatic logic [7:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0:    hex_glyph = 8'hC0;
            4'h1:    hex_glyph = 8'hF9;
            4'h2:    hex_glyph = 8'hA4;
            4'h3:    hex_glyph = 8'hB0;
            4'h4:    hex_glyph = 8'h99;
            4'h5:    hex_glyph = 8'h92;
            4'h6:    hex_glyph = 8'h82;
            4'h7:    hex_glyph = 8'hF8;
            4'h8:    hex_glyph = 8'h80;
            4'h9:    hex_glyph = 8'h90;
            4'hA:    hex_glyph = 8'h88;
            4'hB:    hex_glyph = 8'h83;
            4'hC:    hex_glyph = 8'hC6;
            4'hD:    hex_glyph = 8'hA1;
            4'hE:    hex_glyph = 8'h86;
            default: hex_glyph = 8'h8E;
        endcase
    endfunction

    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic [CHANNELS-1:0] w_state;
    logic [CHANNELS-1:0] w_rise;
    logic [3:0]          r_tcnt [CHANNELS];
    logic [7:0]          w_hex  [6];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.SW;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SWITCH_HEX_MONITOR_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [CHANNELS-1:0] r_state;
    logic [CHANNELS-1:0] w_accept;
    logic [CW-1:0]       r_dcnt [CHANNELS];

    // Accept on the cycle the run of differing samples reaches DEBOUNCE_CYCLES.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_accept[i] = (r_sync2[i] != r_state[i]) &&
                          (r_dcnt[i] == CW'(DEBOUNCE_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= '0;
            for (int i = 0; i < CHANNELS; i++) r_dcnt[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if ((r_sync2[i] == r_state[i]) || w_accept[i]) r_dcnt[i] <= '0;
                else                                           r_dcnt[i] <= r_dcnt[i] + 1'b1;
                if (w_accept[i]) r_state[i] <= r_sync2[i];
            end
        end
    end

    assign w_state = r_state;
    assign w_rise  = w_accept & r_sync2;
`else
    // Rise is flagged on the edge where the synchroniser output goes high.
    assign w_state = r_sync2;
    assign w_rise  = r_sync1 & ~r_sync2;
`endif

    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (!reset_n || bus.clr) r_tcnt[i] <= '0;
            else if (w_rise[i])      r_tcnt[i] <= r_tcnt[i] + 4'd1;
        end
    end

    assign bus.LEDR = w_state;

    // Digits read clr directly so a clear shows as 0 on the very next edge.
    for (genvar g = 0; g < 6; g++) begin : g_hex
        if (g < CHANNELS) begin : g_act
            logic [7:0] r_seg;
            always_ff @(posedge clk) begin
                if (!reset_n)      r_seg <= 8'hC0;
                else if (bus.mode) r_seg <= hex_glyph(bus.clr ? 4'd0 : r_tcnt[g]);
                else               r_seg <= w_state[g] ? 8'hF9 : 8'hC0;
            end
            assign w_hex[g] = r_seg;
        end else begin : g_off
            assign w_hex[g] = 8'hFF;
        end
    end

    assign bus.HEX0 = w_hex[0];
    assign bus.HEX1 = w_hex[1];
    assign bus.HEX2 = w_hex[2];
    assign bus.HEX3 = w_hex[3];
    assign bus.HEX4 = w_hex[4];
    assign bus.HEX5 = w_hex[5];

endmodule

// File: tb/tb_switch_hex_monitor.sv
// Directed bench for switch_hex_monitor (CHANNELS=4, DEBOUNCE_CYCLES=4), both debounce builds.
module tb_switch_hex_monitor;
    localparam int CH = 4;
    localparam int DB = 4;
`ifdef SWITCH_HEX_MONITOR_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    switch_hex_monitor_if #(.CHANNELS(CH)) bus ();

    switch_hex_monitor #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [7:0] hx [6];
    assign hx[0] = bus.HEX0;
    assign hx[1] = bus.HEX1;
    assign hx[2] = bus.HEX2;
    assign hx[3] = bus.HEX3;
    assign hx[4] = bus.HEX4;
    assign hx[5] = bus.HEX5;

    typedef struct {
        logic [3:0] sw;
        logic       mode;
        logic       clr;
        logic [3:0] led;
        logic [7:0] h [4];
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] led,
                             input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        check({tag, "_ledr"}, {4'h0, bus.LEDR}, {4'h0, led});
        check({tag, "_hex0"}, hx[0], e0);
        check({tag, "_hex1"}, hx[1], e1);
        check({tag, "_hex2"}, hx[2], e2);
        check({tag, "_hex3"}, hx[3], e3);
        check({tag, "_hex4"}, hx[4], 8'hFF);
        check({tag, "_hex5"}, hx[5], 8'hFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0000, 1'b0, 1'b0, 4'b0000, '{8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        tbl[1] = '{4'b0101, 1'b0, 1'b0, 4'b0101, '{8'hF9, 8'hC0, 8'hF9, 8'hC0}};
        tbl[2] = '{4'b0101, 1'b1, 1'b0, 4'b0101, '{8'hF9, 8'hC0, 8'hF9, 8'hC0}};
        tbl[3] = '{4'b1111, 1'b1, 1'b0, 4'b1111, '{8'hF9, 8'hF9, 8'hF9, 8'hF9}};
        tbl[4] = '{4'b0000, 1'b1, 1'b0, 4'b0000, '{8'hF9, 8'hF9, 8'hF9, 8'hF9}};
        tbl[5] = '{4'b1011, 1'b1, 1'b0, 4'b1011, '{8'hA4, 8'hA4, 8'hF9, 8'hA4}};
        tbl[6] = '{4'b1011, 1'b0, 1'b0, 4'b1011, '{8'hF9, 8'hF9, 8'hC0, 8'hF9}};
        tbl[7] = '{4'b1011, 1'b1, 1'b1, 4'b1011, '{8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        tbl[8] = '{4'b0000, 1'b1, 1'b0, 4'b0000, '{8'hC0, 8'hC0, 8'hC0, 8'hC0}};
        tbl[9] = '{4'b1000, 1'b1, 1'b0, 4'b1000, '{8'hC0, 8'hC0, 8'hC0, 8'hF9}};

        // Reset with switches 1 and 3 already up
        bus.SW = 4'b1010; bus.mode = 1'b0; bus.clr = 1'b0; reset_n = 1'b0;
        step(3);
        check_all("rst", 4'b0000, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
        reset_n = 1'b1;
        step(LAT - 1);
        check("rel_led_early", {4'h0, bus.LEDR}, 8'h00);
        step(1);
        check("rel_led", {4'h0, bus.LEDR}, 8'h0A);
        check("rel_hex1_early", hx[1], 8'hC0);
        step(1);
        check_all("rel_hex", 4'b1010, 8'hC0, 8'hF9, 8'hC0, 8'hF9);

        // Fresh reset with all switches down, then the steady-state table
        reset_n = 1'b0; bus.SW = 4'b0000;
        step(3);
        reset_n = 1'b1;
        step(2);
        for (int k = 0; k < 10; k++) begin
            bus.SW = tbl[k].sw; bus.mode = tbl[k].mode; bus.clr = tbl[k].clr;
            step(8);
            check_all($sformatf("v%0d", k), tbl[k].led, tbl[k].h[0], tbl[k].h[1], tbl[k].h[2], tbl[k].h[3]);
        end
        bus.clr = 1'b0;

        // clr on the same edge as the accepted rise of SW[1]
        bus.SW = 4'b1010;
        step(LAT - 1);
        bus.clr = 1'b1;
        step(1);
        bus.clr = 1'b0;
        check("clrrise_led", {4'h0, bus.LEDR}, 8'h0A);
        step(1);
        check("clrrise_hex1", hx[1], 8'hC0);
        step(4);
        check("clrrise_hex1_hold", hx[1], 8'hC0);
        check("clrrise_hex3", hx[3], 8'hC0);

        // Build count3 = 10 with SW[3] finishing up, then toggle mode
        for (int k = 0; k < 10; k++) begin
            bus.SW[3] = 1'b0; step(8);
            bus.SW[3] = 1'b1; step(8);
        end
        check("cnt10_hex3", hx[3], 8'h88);
        bus.mode = 1'b0; step(1);
        check("mode0_hex3", hx[3], 8'hF9);
        bus.mode = 1'b1; step(1);
        check("mode1_hex3", hx[3], 8'h88);
        bus.mode = 1'b0; step(1);
        check("mode0b_hex3", hx[3], 8'hF9);

        // 17 rises on SW[2] wrap the count to 1
        bus.mode = 1'b1; bus.clr = 1'b1; step(1); bus.clr = 1'b0;
        for (int k = 0; k < 17; k++) begin
            bus.SW[2] = 1'b1; step(8);
            bus.SW[2] = 1'b0; step(8);
            if (k == 15) check("wrap16_hex2", hx[2], 8'hC0);
        end
        check("wrap17_hex2", hx[2], 8'hF9);
        check("wrap17_led2", {7'h0, bus.LEDR[2]}, 8'h00);

        bus.clr = 1'b1; step(1); bus.clr = 1'b0;
`ifdef SWITCH_HEX_MONITOR_DEBOUNCE_EN
        // Short and interrupted glitches are rejected, a long high is accepted
        bus.SW[0] = 1'b1; step(3); bus.SW[0] = 1'b0; step(8);
        check("glitch_led0", {7'h0, bus.LEDR[0]}, 8'h00);
        check("glitch_hex0", hx[0], 8'hC0);
        bus.SW[0] = 1'b1; step(3); bus.SW[0] = 1'b0; step(1);
        bus.SW[0] = 1'b1; step(3); bus.SW[0] = 1'b0; step(8);
        check("broken_led0", {7'h0, bus.LEDR[0]}, 8'h00);
        check("broken_hex0", hx[0], 8'hC0);
        bus.SW[0] = 1'b1;
        step(LAT - 1);
        check("long_led0_early", {7'h0, bus.LEDR[0]}, 8'h00);
        step(1);
        check("long_led0", {7'h0, bus.LEDR[0]}, 8'h01);
        step(1);
        check("long_hex0", hx[0], 8'hF9);
        bus.SW[0] = 1'b0; step(8);
`else
        // A single-cycle pulse passes straight through the synchroniser
        bus.SW[0] = 1'b1; step(1); bus.SW[0] = 1'b0;
        check("pulse_led0_e1", {7'h0, bus.LEDR[0]}, 8'h00);
        step(1);
        check("pulse_led0_e2", {7'h0, bus.LEDR[0]}, 8'h01);
        step(1);
        check("pulse_led0_e3", {7'h0, bus.LEDR[0]}, 8'h00);
        check("pulse_hex0", hx[0], 8'hF9);
        step(4);
        check("pulse_hex0_hold", hx[0], 8'hF9);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
